dma_burst_mem: RTL and testbench

- Memory-side consumer of the DMA engine's burst writes; sits directly downstream of the DMA block.
- Accepts a 4-word (64-bit) burst on the DMA port and writes it to consecutive word addresses after a fixed latency.
- Reports completion with a one-cycle doneM pulse.
- Also serves single-word CPU reads/writes when the DMA port is idle, so the CPU and the DMA share one array behind one busy/ready FSM.

---
 rtl/dma_burst_mem.sv | 170 +++++++++++++++++
 tb/tb_dma_burst_mem.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dma_burst_mem.sv
`default_nettype none
// ============================================================================
// Module  : dma_burst_mem
// Brief   : Shared word memory taking 4-word DMA bursts and single-word CPU
//           accesses through one fixed-latency busy/ready FSM.
// Revision: 1.0 - initial release
// ============================================================================
module dma_burst_mem #(
    parameter int WORD_SIZE = 16,
    parameter int MEM_WORDS = 256,
    parameter int LATENCY   = 2
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   WRITE,
    input  logic [WORD_SIZE-1:0]   addr,
    input  logic [4*WORD_SIZE-1:0] data,
    output logic                   doneM,
    input  logic                   readM,
    input  logic                   writeM,
    input  logic [WORD_SIZE-1:0]   cpu_addr,
    input  logic [WORD_SIZE-1:0]   cpu_wdata,
    output logic [WORD_SIZE-1:0]   cpu_rdata,
    output logic                   readyM
);

    localparam int         c_IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int         c_EXT_W    = WORD_SIZE + 1;
    localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DMA_BUSY = 2'd1,
        S_CPU_BUSY = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    // One extra bit so base+3 cannot overflow before the modulo.
    function automatic logic [c_IDX_W-1:0] wrap_idx(input logic [c_EXT_W-1:0] a);
        logic [c_EXT_W-1:0] m;
        m = a % c_EXT_W'(MEM_WORDS);
        return m[c_IDX_W-1:0];
    endfunction

    logic [WORD_SIZE-1:0]   mem_q [MEM_WORDS];

    state_t                 state_q,     state_d;
    logic [3:0]             cnt_q,       cnt_d;
    logic                   done_q,      done_d;
    logic                   ready_q,     ready_d;
    logic [WORD_SIZE-1:0]   rdata_q,     rdata_d;
    logic [c_IDX_W-1:0]     base_q,      base_d;
    logic [4*WORD_SIZE-1:0] burst_q,     burst_d;
    logic [c_IDX_W-1:0]     cpu_idx_q,   cpu_idx_d;
    logic [WORD_SIZE-1:0]   cpu_wdata_q, cpu_wdata_d;
    logic                   cpu_wr_q,    cpu_wr_d;

    logic                   w_dma_we;
    logic                   w_cpu_we;
    logic [c_IDX_W-1:0]     w_lane_idx [4];

    generate
        for (genvar g = 0; g < 4; g++) begin : g_lane
            assign w_lane_idx[g] = wrap_idx(c_EXT_W'(base_q) + c_EXT_W'(g));
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        ready_d     = 1'b0;
        rdata_d     = rdata_q;
        base_d      = base_q;
        burst_d     = burst_q;
        cpu_idx_d   = cpu_idx_q;
        cpu_wdata_d = cpu_wdata_q;
        cpu_wr_d    = cpu_wr_q;
        w_dma_we    = 1'b0;
        w_cpu_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // DMA has priority; a concurrent CPU level request waits.
                if (WRITE) begin
                    base_d  = wrap_idx({1'b0, addr});
                    burst_d = data;
                    cnt_d   = c_CNT_INIT;
                    state_d = S_DMA_BUSY;
                end else if (readM || writeM) begin
                    cpu_idx_d   = wrap_idx({1'b0, cpu_addr});
                    cpu_wdata_d = cpu_wdata;
                    cpu_wr_d    = writeM;
                    cnt_d       = c_CNT_INIT;
                    state_d     = S_CPU_BUSY;
                end
            end
            S_DMA_BUSY: begin
                if (cnt_q == 4'd0) begin
                    w_dma_we = 1'b1;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_CPU_BUSY: begin
                if (cnt_q == 4'd0) begin
                    if (cpu_wr_q) begin
                        w_cpu_we = 1'b1;
                    end else begin
                        rdata_d = mem_q[cpu_idx_q];
                    end
                    ready_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge CLK) begin
        base_q      <= base_d;
        burst_q     <= burst_d;
        cpu_idx_q   <= cpu_idx_d;
        cpu_wdata_q <= cpu_wdata_d;
        cpu_wr_q    <= cpu_wr_d;
    end

    // Reset during the commit edge must leave the array untouched.
    always_ff @(posedge CLK) begin
        if (!RESET && w_dma_we) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[w_lane_idx[i]] <= burst_q[i*WORD_SIZE +: WORD_SIZE];
            end
        end
        if (!RESET && w_cpu_we) begin
            mem_q[cpu_idx_q] <= cpu_wdata_q;
        end
    end

    assign doneM     = done_q;
    assign readyM    = ready_q;
    assign cpu_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_burst_mem.sv
`default_nettype none
// ============================================================================
// Module  : tb_dma_burst_mem
// Brief   : Self-checking bench for dma_burst_mem (LATENCY=2 and LATENCY=1).
// Revision: 1.0 - initial release
// ============================================================================
module tb_dma_burst_mem;

    localparam int LAT = 2;

    typedef enum logic [1:0] {OP_DMA, OP_WR, OP_RD, OP_RW} op_e;
    typedef struct {
        op_e         op;
        logic [15:0] a;
        logic [63:0] d;
        logic [15:0] exp;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        WRITE, readM, writeM, doneM, readyM;
    logic [15:0] addr, cpu_addr, cpu_wdata, cpu_rdata;
    logic [63:0] data;
    logic        l1_WRITE, l1_readM, l1_writeM, l1_doneM, l1_readyM;
    logic [15:0] l1_addr, l1_cpu_addr, l1_cpu_wdata, l1_cpu_rdata;
    logic [63:0] l1_data;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] sb_q [$];
    logic [15:0] last_rd, l1_last_rd;
    vec_t        tbl [16];

    always #5 CLK = ~CLK;

    dma_burst_mem #(.WORD_SIZE(16), .MEM_WORDS(256), .LATENCY(LAT)) dut (
        .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .addr(addr), .data(data),
        .doneM(doneM), .readM(readM), .writeM(writeM), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .readyM(readyM)
    );

    dma_burst_mem #(.WORD_SIZE(16), .MEM_WORDS(256), .LATENCY(1)) dut_l1 (
        .CLK(CLK), .RESET(RESET), .WRITE(l1_WRITE), .addr(l1_addr), .data(l1_data),
        .doneM(l1_doneM), .readM(l1_readM), .writeM(l1_writeM), .cpu_addr(l1_cpu_addr),
        .cpu_wdata(l1_cpu_wdata), .cpu_rdata(l1_cpu_rdata), .readyM(l1_readyM)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input bit l1, input op_e op, input logic [15:0] a,
                           input logic [63:0] d, input bit on);
        if (!l1) begin
            WRITE  = on && (op == OP_DMA);
            writeM = on && (op == OP_WR || op == OP_RW);
            readM  = on && (op == OP_RD || op == OP_RW);
            if (op == OP_DMA) begin addr = a; data = d; end
            else begin cpu_addr = a; cpu_wdata = d[15:0]; end
        end else begin
            l1_WRITE  = on && (op == OP_DMA);
            l1_writeM = on && (op == OP_WR || op == OP_RW);
            l1_readM  = on && (op == OP_RD || op == OP_RW);
            if (op == OP_DMA) begin l1_addr = a; l1_data = d; end
            else begin l1_cpu_addr = a; l1_cpu_wdata = d[15:0]; end
        end
    endtask

    // Issue one request, wait for its completion pulse, score the result.
    task automatic do_op(input bit l1, input vec_t v, input string tag);
        int          n;
        int          lat_exp;
        logic        pd, pr;
        logic [15:0] rd, exp;
        lat_exp = l1 ? 1 : LAT;
        set_req(l1, v.op, v.a, v.d, 1'b1);
        if (v.op == OP_RD) sb_q.push_back(v.exp);
        @(posedge CLK); #1;
        set_req(l1, v.op, v.a, v.d, 1'b0);
        n = 0; pd = 1'b0; pr = 1'b0;
        while (n < 20 && !(pd || pr)) begin
            @(posedge CLK); #1;
            n++;
            pd = l1 ? l1_doneM : doneM;
            pr = l1 ? l1_readyM : readyM;
            check({tag, " exclusive"}, 64'(pd & pr), 64'd0);
        end
        check({tag, " latency"}, 64'(n), 64'(lat_exp));
        check({tag, " kind"}, {62'd0, pd, pr}, (v.op == OP_DMA) ? 64'd2 : 64'd1);
        rd = l1 ? l1_cpu_rdata : cpu_rdata;
        if (v.op == OP_RD) begin
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
            check({tag, " rdata"}, 64'(rd), 64'(exp));
            if (l1) l1_last_rd = exp; else last_rd = exp;
        end else if (v.op != OP_DMA) begin
            check({tag, " rdata hold"}, 64'(rd), 64'(l1 ? l1_last_rd : last_rd));
        end
        @(posedge CLK); #1;
        check({tag, " pulse clear"},
              {62'd0, (l1 ? l1_doneM : doneM), (l1 ? l1_readyM : readyM)}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1;
        set_req(1'b0, OP_DMA, 16'h0, 64'h0, 1'b0);
        set_req(1'b1, OP_DMA, 16'h0, 64'h0, 1'b0);
        cpu_addr = 16'h0; cpu_wdata = 16'h0; l1_cpu_addr = 16'h0; l1_cpu_wdata = 16'h0;
        last_rd = 16'h0; l1_last_rd = 16'h0;

        tbl[0]  = '{OP_WR,  16'h0010, 64'hA010, 16'h0};
        tbl[1]  = '{OP_WR,  16'h0011, 64'hA011, 16'h0};
        tbl[2]  = '{OP_WR,  16'h0012, 64'hA012, 16'h0};
        tbl[3]  = '{OP_WR,  16'h0013, 64'hA013, 16'h0};
        tbl[4]  = '{OP_DMA, 16'h0020, 64'h4444_3333_2222_1111, 16'h0};
        tbl[5]  = '{OP_RD,  16'h0021, 64'h0, 16'h2222};
        tbl[6]  = '{OP_RD,  16'h0020, 64'h0, 16'h1111};
        tbl[7]  = '{OP_RD,  16'h0022, 64'h0, 16'h3333};
        tbl[8]  = '{OP_RD,  16'h0023, 64'h0, 16'h4444};
        tbl[9]  = '{OP_DMA, 16'h00FE, 64'hDDDD_CCCC_BBBB_AAAA, 16'h0};
        tbl[10] = '{OP_RD,  16'h00FE, 64'h0, 16'hAAAA};
        tbl[11] = '{OP_RD,  16'h00FF, 64'h0, 16'hBBBB};
        tbl[12] = '{OP_RD,  16'h0000, 64'h0, 16'hCCCC};
        tbl[13] = '{OP_RD,  16'h0001, 64'h0, 16'hDDDD};
        tbl[14] = '{OP_RW,  16'h0050, 64'h5A5A, 16'h0};
        tbl[15] = '{OP_RD,  16'h1F50, 64'h0, 16'h5A5A};

        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        check("reset doneM", 64'(doneM), 64'd0);
        check("reset readyM", 64'(readyM), 64'd0);
        check("reset cpu_rdata", 64'(cpu_rdata), 64'd0);
        check("reset l1 doneM", 64'(l1_doneM), 64'd0);
        check("reset l1 readyM", 64'(l1_readyM), 64'd0);

        for (int i = 0; i < 16; i++) do_op(1'b0, tbl[i], $sformatf("vec%0d", i));

        // Reset while the burst to 0x10 is in flight aborts the commit.
        set_req(1'b0, OP_DMA, 16'h0010, 64'hDEAD_DEAD_DEAD_DEAD, 1'b1);
        @(posedge CLK); #1;
        set_req(1'b0, OP_DMA, 16'h0010, 64'h0, 1'b0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK); #1;
            check($sformatf("abort doneM r%0d", i), 64'(doneM), 64'd0);
        end
        RESET = 1'b0;
        last_rd = 16'h0; l1_last_rd = 16'h0;
        check("abort cpu_rdata", 64'(cpu_rdata), 64'd0);
        check("abort readyM", 64'(readyM), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            check($sformatf("abort idle doneM %0d", i), 64'(doneM), 64'd0);
        end
        for (int i = 0; i < 4; i++)
            do_op(1'b0, '{OP_RD, 16'(16'h0010 + i), 64'h0, 16'(16'hA010 + i)},
                  $sformatf("abort rd%0d", i));

        // WRITE held: one pulse per acceptance, re-acceptance only from IDLE.
        set_req(1'b0, OP_DMA, 16'h0040, 64'h0004_0003_0002_0001, 1'b1);
        for (int i = 0; i <= 10; i++) begin
            @(posedge CLK); #1;
            check($sformatf("held doneM e%0d", i), 64'(doneM), 64'(i == 2 || i == 6));
            if (i == 6) set_req(1'b0, OP_DMA, 16'h0040, 64'h0, 1'b0);
        end
        do_op(1'b0, '{OP_RD, 16'h0043, 64'h0, 16'h0004}, "held rd");

        // DMA and CPU write together: DMA first, CPU served after DONE.
        WRITE = 1'b1; addr = 16'h0030; data = 64'h3333_2222_1111_7777;
        writeM = 1'b1; cpu_addr = 16'h0005; cpu_wdata = 16'hBEEF;
        for (int i = 0; i <= 8; i++) begin
            @(posedge CLK); #1;
            check($sformatf("arb doneM e%0d", i), 64'(doneM), 64'(i == 2));
            check($sformatf("arb readyM e%0d", i), 64'(readyM), 64'(i == 6));
            if (i == 2) WRITE = 1'b0;
            if (i == 6) writeM = 1'b0;
        end
        do_op(1'b0, '{OP_RD, 16'h0005, 64'h0, 16'hBEEF}, "arb rd cpu");
        do_op(1'b0, '{OP_RD, 16'h0030, 64'h0, 16'h7777}, "arb rd dma");

        do_op(1'b1, '{OP_WR,  16'h0021, 64'h2222, 16'h0}, "l1 wr");
        do_op(1'b1, '{OP_RD,  16'h0021, 64'h0, 16'h2222}, "l1 rd");
        do_op(1'b1, '{OP_DMA, 16'h00FF, 64'h0D0D_0C0C_0B0B_0A0A, 16'h0}, "l1 dma");
        do_op(1'b1, '{OP_RD,  16'h0002, 64'h0, 16'h0D0D}, "l1 rd wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
